// File: rtl/smax_reduce_if.sv
// Common fixed-point context shared by the datapath blocks: clock, reset and
// the element width that every attached block derives its data ports from.
interface fixedp #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset
);

  modport master (input clk, input reset);
  modport slave  (input clk, input reset);

endinterface

// File: rtl/smax_reduce.sv
// Streaming signed extremum reducer: folds each first/last-framed vector into
// its max (or min), the index of that element and the element count.
module smax_reduce #(
  parameter int IDXW     = 8,
  parameter bit DEF_MODE = 1'b0
) (
  fixedp.slave                      g,
  input  logic                      mode_sel,
  input  logic signed [g.WIDTH-1:0] in_data,
  input  logic                      in_valid,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic signed [g.WIDTH-1:0] out_data,
  output logic [IDXW-1:0]           out_idx,
  output logic [IDXW:0]             out_count,
  output logic                      out_ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      abort
);

  localparam int W = g.WIDTH;
  localparam logic [IDXW:0] CNT_MAX = {1'b1, {IDXW{1'b0}}};
  localparam logic [IDXW:0] CNT_ONE = {{IDXW{1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e              state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [IDXW:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                mode_q, mode_d;

  logic                out_valid_q;
  logic signed [W-1:0] out_data_q;
  logic [IDXW-1:0]     out_idx_q;
  logic [IDXW:0]       out_count_q;
  logic                out_ovf_q;
  logic                abort_q;

  logic beat;
  logic start;
  logic better;

  // Input only stalls while a result is held that downstream has not taken.
  assign in_ready = !out_valid_q || out_ready;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    beat    = in_valid && in_ready;
    start   = (state_q == IDLE) || in_first;
    better  = mode_q ? (in_data < acc_q) : (in_data > acc_q);
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;

    if (beat) begin
      if (start) begin
        acc_d  = in_data;
        idx_d  = '0;
        cnt_d  = CNT_ONE;
        ovf_d  = 1'b0;
        mode_d = mode_sel;
      end else begin
        // Strict compare keeps the earliest index on ties; once the beat
        // index no longer fits in IDXW bits the reported index freezes.
        if (better) begin
          acc_d = in_data;
          if (cnt_q != CNT_MAX) idx_d = cnt_q[IDXW-1:0];
        end
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_ONE;
      end
      state_d = in_last ? IDLE : ACCUM;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge g.clk or posedge g.reset) begin
    if (g.reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      mode_q      <= DEF_MODE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      abort_q <= beat && (state_q == ACCUM) && in_first;

      // A new last beat may land in the same cycle the old result drains.
      if (beat && in_last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_d;
        out_idx_q   <= idx_d;
        out_count_q <= cnt_d;
        out_ovf_q   <= ovf_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign abort     = abort_q;

endmodule
